ii_rd_arbiter: RTL and testbench
================================

Name: ii_rd_arbiter

Overview:
- Shares the single read port of the integral-image block RAM (15-bit address, 20-bit data) between two requesters:
  - the VGA display unpacker, which is hard real-time;
  - the face-detector window evaluator, which is best-effort.
- The display always wins. The detector gets idle slots through a req/gnt handshake.
- Read data is routed back to its owner using a latency-matched tag pipeline.
- Sits between the II memory and both consumers, in the clk_vga domain.

Parameters:
- ADDR_W, 15, memory address width
- DATA_W, 20, memory data width
- RD_LAT, 1, block RAM read latency in cycles (1..3)
- STARVE_LIMIT, 200, consecutive detector-wait cycles before starve_flag sets

Ports:
- clk_vga  in  1  single clock (VGA pixel clock)
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical sync; clears per-frame state
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid
- det_req  in  1  detector read request; held until granted
- det_addr  in  ADDR_W  detector read address; stable while det_req=1 and not granted
- det_gnt  out  1  detector request accepted this cycle
- det_rdata  out  DATA_W  detector read data
- det_rvalid  out  1  det_rdata valid
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after mem_en
- starve_flag  out  1  sticky; detector waited STARVE_LIMIT consecutive cycles this frame

Behaviour:
- Reset (rst_n=0, async):
  - det_gnt, disp_rvalid, det_rvalid, mem_en, starve_flag = 0.
  - Tag pipe, wait counter and FSM cleared; FSM state = FRAME_IDLE.
- Arbitration (combinational, same cycle):
  - disp_req=1: mem_en=1, mem_addr=disp_addr, det_gnt=0.
  - Else if det_req=1 and state=FRAME_ACTIVE: mem_en=1, mem_addr=det_addr, det_gnt=1.
  - Else mem_en=0, mem_addr holds its last value.
- The display is never stalled or delayed. The detector only sees det_gnt on cycles with disp_req=0.
- Tag pipe:
  - Each cycle, a 2-bit tag {disp,det} shifts in; {0,0} when mem_en=0.
  - The pipe is RD_LAT stages deep.
  - disp_rvalid = disp bit at the pipe output; det_rvalid = det bit at the pipe output.
  - disp_rdata = det_rdata = mem_rdata (pass-through); consumers qualify with their own rvalid.
  - disp_rvalid and det_rvalid are never both 1.
  - Total read latency = RD_LAT for both requesters.
- FSM:
  - FRAME_IDLE: on frame_start -> FRAME_ACTIVE. Detector is not granted; display is still served.
  - FRAME_ACTIVE: frame_start -> FRAME_ACTIVE, with per-frame state cleared.
  - FRAME_ACTIVE stays otherwise.
- Wait counter (saturating):
  - Increments each cycle with det_req=1 and det_gnt=0.
  - Clears on det_gnt, on det_req=0, or on frame_start.
  - Reaching STARVE_LIMIT sets starve_flag.
  - starve_flag clears only on frame_start or reset.
  - If the limit is reached in the same cycle as frame_start, frame_start wins and the flag stays 0.
- Boundary conditions:
  - Simultaneous disp_req and det_req: display served; detector waits.
  - Back-to-back detector grants allowed, one per cycle.
  - Reset mid-flight: in-flight tags are discarded and no rvalid is issued after reset.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds outputs det_grant_cnt (16 bit) and disp_read_cnt (16 bit).
  - Both saturate at 16'hFFFF.
  - Both are latched into the output registers and cleared internally on frame_start, so the outputs show the previous frame's totals.
  - Both reset to 0.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then frame_start, then det_req=1 with det_addr=0x0123 and disp_req=0 -> det_gnt=1 the same cycle; mem_addr=0x0123; det_rvalid=1 exactly RD_LAT cycles later with data = mem model at 0x0123.
- disp_req=1 held for 160 cycles while det_req=1 -> det_gnt=0 throughout, 160 disp_rvalid pulses in order; on cycle 161 (disp_req=0), det_gnt=1.
- Alternate disp_req 1/0 every cycle with det_req=1 -> interleaved grants; disp_rvalid and det_rvalid are never both 1; every returned datum matches its address.
- STARVE_LIMIT=8, disp_req=1 and det_req=1 for 10 cycles -> starve_flag=1 after 8 waiting cycles; the flag remains 1 after disp_req drops; frame_start clears it to 0.
- Before any frame_start, det_req=1 and disp_req=0 -> det_gnt=0; disp_req still served.
- rst_n asserted with 2 reads in flight (RD_LAT=3) -> rvalids 0 immediately and no late rvalid after release.

Source files
------------

// File: rtl/ii_rd_arbiter.sv
// Integral-image RAM read-port arbiter: display has absolute priority, the detector takes idle slots.
// Optional per-frame statistics outputs are enabled by defining ARB_STATS_EN.
module ii_rd_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 20,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 200
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic [DATA_W-1:0] det_rdata,
  output logic              det_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve_flag
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       det_grant_cnt,
  output logic [15:0]       disp_read_cnt
`endif
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(STARVE_LIMIT - 1);

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        tag_pipe [RD_LAT];
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) state <= FRAME_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    det_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = addr_q;
    case (state)
      FRAME_IDLE:   if (frame_start) state_next = FRAME_ACTIVE;
      FRAME_ACTIVE: state_next = FRAME_ACTIVE;
      default:      state_next = FRAME_IDLE;
    endcase
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (det_req && state == FRAME_ACTIVE) begin
      mem_en   = 1'b1;
      mem_addr = det_addr;
      det_gnt  = 1'b1;
    end
  end

  // Remember the last issued address so mem_addr is stable on idle cycles.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)      addr_q <= '0;
    else if (mem_en) addr_q <= mem_addr;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= {disp_req, det_gnt};
      for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign disp_rvalid = tag_pipe[RD_LAT-1][1];
  assign det_rvalid  = tag_pipe[RD_LAT-1][0];
  assign disp_rdata  = mem_rdata;
  assign det_rdata   = mem_rdata;

  // The flag is set on the same edge the counter reaches the limit; frame_start overrides.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      starve_flag <= 1'b0;
    end else if (frame_start) begin
      wait_cnt    <= '0;
      starve_flag <= 1'b0;
    end else if (det_req && !det_gnt) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_PRE) starve_flag <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] grant_acc, read_acc;

  // A grant or read in the frame_start cycle is counted towards the new frame.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      grant_acc     <= '0;
      read_acc      <= '0;
      det_grant_cnt <= '0;
      disp_read_cnt <= '0;
    end else if (frame_start) begin
      det_grant_cnt <= grant_acc;
      disp_read_cnt <= read_acc;
      grant_acc     <= 16'(det_gnt);
      read_acc      <= 16'(disp_req);
    end else begin
      if (det_gnt && grant_acc != '1) grant_acc <= grant_acc + 16'd1;
      if (disp_req && read_acc != '1) read_acc <= read_acc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ii_rd_arbiter.sv
// Scoreboard bench for ii_rd_arbiter (RD_LAT=3, STARVE_LIMIT=8) with a latency-modelled RAM.
module tb_ii_rd_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 20;
  localparam int LAT = 3;
  localparam int LIM = 8;

  logic          clk_vga = 1'b0;
  logic          rst_n;
  logic          frame_start = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          det_req = 1'b0;
  logic [AW-1:0] det_addr = '0;
  logic          det_gnt;
  logic [DW-1:0] det_rdata;
  logic          det_rvalid;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          starve_flag;

  ii_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .frame_start(frame_start),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .det_req(det_req), .det_addr(det_addr), .det_gnt(det_gnt), .det_rdata(det_rdata),
    .det_rvalid(det_rvalid), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .starve_flag(starve_flag)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 20'h5A5A5;
  endfunction

  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk_vga) begin
    rd_pipe[0] <= mem_f(mem_addr);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t disp_q[$];
  exp_t det_q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read returns; also flags overdue entries.
  always @(negedge clk_vga) if (mon_en) begin
    exp_t e;
    if (disp_rvalid || det_rvalid) chk("rvalid_exclusive", {31'd0, disp_rvalid & det_rvalid}, 32'd0);
    while (disp_q.size() > 0 && disp_q[0].due < cyc) begin
      chk("disp_missing", 32'(disp_q[0].due), 32'(cyc));
      void'(disp_q.pop_front());
    end
    while (det_q.size() > 0 && det_q[0].due < cyc) begin
      chk("det_missing", 32'(det_q[0].due), 32'(cyc));
      void'(det_q.pop_front());
    end
    if (disp_rvalid) begin
      if (disp_q.size() == 0) chk("disp_unexpected", 32'd1, 32'd0);
      else begin
        e = disp_q.pop_front();
        chk("disp_data", 32'(disp_rdata), 32'(e.data));
        chk("disp_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (det_rvalid) begin
      if (det_q.size() == 0) chk("det_unexpected", 32'd1, 32'd0);
      else begin
        e = det_q.pop_front();
        chk("det_data", 32'(det_rdata), 32'(e.data));
        chk("det_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  logic          exp_active = 1'b0;
  int            exp_wait = 0;
  logic          exp_starve = 1'b0;
  logic [AW-1:0] exp_last = '0;

  task automatic model_reset();
    exp_active = 1'b0;
    exp_wait   = 0;
    exp_starve = 1'b0;
    exp_last   = '0;
  endtask

  // One clock cycle of stimulus, with same-cycle arbitration checks and scoreboard pushes.
  task automatic step(input logic fs, input logic dr, input logic [AW-1:0] da,
                      input logic tr, input logic [AW-1:0] ta);
    logic          g;
    logic [AW-1:0] ea;
    exp_t          e;
    @(posedge clk_vga);
    #1;
    frame_start = fs; disp_req = dr; disp_addr = da; det_req = tr; det_addr = ta;
    #1;
    g  = tr && !dr && exp_active;
    ea = dr ? da : (g ? ta : exp_last);
    chk("det_gnt", {31'd0, det_gnt}, {31'd0, g});
    chk("mem_en", {31'd0, mem_en}, {31'd0, dr | g});
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("starve_flag", {31'd0, starve_flag}, {31'd0, exp_starve});
    exp_last = ea;
    if (dr) begin e.data = mem_f(da); e.due = cyc + LAT; disp_q.push_back(e); end
    if (g)  begin e.data = mem_f(ta); e.due = cyc + LAT; det_q.push_back(e);  end
    if (fs) begin
      exp_active = 1'b1; exp_wait = 0; exp_starve = 1'b0;
    end else if (tr && !g) begin
      if (exp_wait < LIM) exp_wait++;
      if (exp_wait == LIM) exp_starve = 1'b1;
    end else begin
      exp_wait = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [AW-1:0] dta;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_det_gnt", {31'd0, det_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_disp_rvalid", {31'd0, disp_rvalid}, 32'd0);
    chk("rst_det_rvalid", {31'd0, det_rvalid}, 32'd0);
    chk("rst_starve", {31'd0, starve_flag}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk_vga); #3 rst_n = 1'b1;

    // Before any frame_start the detector is never granted; display still is.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 15'h0055);
    step(1'b0, 1'b1, 15'h0077, 1'b1, 15'h0055);
    idle(1);

    // Single detector read in an active frame.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 15'h0123);
    idle(5);

    // Long display burst with a waiting detector, then the detector wins the first gap.
    for (int i = 0; i < 160; i++) step(1'b0, 1'b1, AW'(15'h4000 + i), 1'b1, 15'h0200);
    step(1'b0, 1'b0, '0, 1'b1, 15'h0200);
    idle(5);

    // Alternating display/detector traffic with back-to-back detector addresses.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    dta = 15'h0400;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 2) == 0, AW'(15'h1000 + i), 1'b1, dta);
      if ((i % 2) != 0) dta = dta + 15'd1;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, dta);
      dta = dta + 15'd1;
    end
    idle(5);

    // Starvation: flag after LIM waits, sticky, cleared by frame_start.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, AW'(15'h2000 + i), 1'b1, 15'h0300);
    idle(3);
    chk("starve_sticky", {31'd0, starve_flag}, 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    chk("starve_cleared", {31'd0, starve_flag}, 32'd0);
    idle(5);

    // Reset with two reads in flight: everything in flight is dropped.
    step(1'b0, 1'b1, 15'h0abc, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 15'h0def);
    @(posedge clk_vga); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_disp_rvalid", {31'd0, disp_rvalid}, 32'd0);
    chk("midrst_det_rvalid", {31'd0, det_rvalid}, 32'd0);
    disp_q.delete();
    det_q.delete();
    model_reset();
    frame_start = 1'b0; disp_req = 1'b0; det_req = 1'b0;
    @(posedge clk_vga); @(posedge clk_vga); #3 rst_n = 1'b1;
    idle(8);

    chk("sb_drain", 32'(disp_q.size() + det_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
